// File: rtl/cost_loader_pkg.sv
// Shared constants and FSM encoding for the cost_loader front-end stage.
package cost_loader_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 6;
  localparam int DEPTH  = N * N;
  localparam int TMO_W  = 21;

  typedef logic [0:0] state_t;

  localparam state_t LOAD = 1'b0;
  localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/cost_loader_if.sv
// Valid/ready stream carrying one 7-bit cost entry per transfer, row-major.
interface cost_loader_if;
  import cost_loader_pkg::*;

  logic              in_valid;
  logic [COST_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/cost_loader_mem.sv
// 64x7 cost register file: one synchronous write port, one combinational read port.
module cost_mem
  import cost_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  wsel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wsel[gi] = we && (waddr == IDX_W'(gi));
    end
  endgenerate

  // Whole array clears on reset so the core never sees a stale matrix.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem_reg[i] <= '0;
      end else if (wsel[i]) begin
        mem_reg[i] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/cost_loader.sv
// Loads an 8x8 cost matrix, holds the core in reset until full, captures its result.
// Optional RUN watchdog enabled by defining COST_LOADER_TIMEOUT_EN.
module cost_loader
  import cost_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              CLK,
  input  logic              RST_N,
  cost_loader_if.slave      s,
  output logic              JAM_RST,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              jam_valid,
  input  logic [SUM_W-1:0]  jam_min,
  input  logic [CNT_W-1:0]  jam_count,
  output logic              res_valid,
  output logic [SUM_W-1:0]  res_min,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TMO_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for the 21-bit watchdog");
  end

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              jam_rst_reg;
  logic              res_valid_reg;
  logic [SUM_W-1:0]  res_min_reg;
  logic [CNT_W-1:0]  res_count_reg;
  logic              xfer;

  assign s.in_ready = (state_reg == LOAD);
  assign xfer       = (state_reg == LOAD) && s.in_valid;

`ifdef COST_LOADER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             res_err_reg;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= LOAD;
      idx_reg       <= '0;
      jam_rst_reg   <= 1'b1;
      res_valid_reg <= 1'b0;
      res_min_reg   <= '0;
      res_count_reg <= '0;
`ifdef COST_LOADER_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
      res_err_reg   <= 1'b0;
`endif
    end else begin
      res_valid_reg <= 1'b0;
`ifdef COST_LOADER_TIMEOUT_EN
      res_err_reg   <= 1'b0;
`endif
      case (state_reg)
        LOAD: begin
          if (xfer) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == IDX_W'(DEPTH - 1)) begin
              state_reg   <= RUN;
              jam_rst_reg <= 1'b0;
`ifdef COST_LOADER_TIMEOUT_EN
              tmo_cnt_reg <= '0;
`endif
            end
          end
        end
        default: begin
          // A real result always beats a watchdog expiry on the same edge.
          if (jam_valid) begin
            res_min_reg   <= jam_min;
            res_count_reg <= jam_count;
            res_valid_reg <= 1'b1;
            state_reg     <= LOAD;
            jam_rst_reg   <= 1'b1;
          end
`ifdef COST_LOADER_TIMEOUT_EN
          else if (tmo_cnt_reg == TO_LAST) begin
            res_min_reg   <= '1;
            res_count_reg <= '0;
            res_valid_reg <= 1'b1;
            res_err_reg   <= 1'b1;
            state_reg     <= LOAD;
            jam_rst_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
      endcase
    end
  end

  cost_mem u_mem (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (xfer),
    .waddr (idx_reg),
    .wdata (s.in_data),
    .raddr ({W, J}),
    .rdata (Cost)
  );

  assign JAM_RST   = jam_rst_reg;
  assign res_valid = res_valid_reg;
  assign res_min   = res_min_reg;
  assign res_count = res_count_reg;
`ifdef COST_LOADER_TIMEOUT_EN
  assign res_err   = res_err_reg;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cost_loader.sv
// Directed self-checking bench for cost_loader (timeout scenarios when COST_LOADER_TIMEOUT_EN is set).
module tb_cost_loader;

  logic       clk;
  logic       rst_n;
  logic [2:0] w;
  logic [2:0] j;
  logic [6:0] cost;
  logic       jam_rst;
  logic       jam_valid;
  logic [9:0] jam_min;
  logic [3:0] jam_count;
  logic       res_valid;
  logic [9:0] res_min;
  logic [3:0] res_count;
  logic       res_err;

  int n_cmp = 0;
  int n_bad = 0;

  cost_loader_if bus ();

  cost_loader #(.TIMEOUT_CYCLES(16)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .s         (bus.slave),
    .JAM_RST   (jam_rst),
    .W         (w),
    .J         (j),
    .Cost      (cost),
    .jam_valid (jam_valid),
    .jam_min   (jam_min),
    .jam_count (jam_count),
    .res_valid (res_valid),
    .res_min   (res_min),
    .res_count (res_count),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive 'count' back-to-back transfers of value base+i; no checking here.
  task automatic push_run(input int count, input int base);
    for (int i = 0; i < count; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 7'((base + i) % 128);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    jam_valid = 1'b0;
    jam_min = '0;
    jam_count = '0;
    w = '0;
    j = '0;
    tick();
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || jam_rst !== 1'b1 || res_valid !== 1'b0 ||
        res_min !== 10'd0 || res_count !== 4'd0 || res_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs ready=%b jam_rst=%b rv=%b rmin=%0d rcnt=%0d rerr=%b required 1 1 0 0 0 0",
               bus.in_ready, jam_rst, res_valid, res_min, res_count, res_err);
    end
    for (int i = 0; i < 64; i++) begin
      {w, j} = 6'(i);
      #1;
      n_cmp++;
      if (cost !== 7'd0) begin
        n_bad++;
        $display("FAIL reset_cost idx=%0d got=%0d required=0", i, cost);
      end
    end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_gaps();
    int n = 0;
    int c = 0;
    logic took;
    while (n < 64 && c < 300) begin
      bus.in_valid = (c % 3 != 2);
      bus.in_data  = 7'(n % 100);
      n_cmp++;
      if (bus.in_ready !== 1'b1 || jam_rst !== 1'b1) begin
        n_bad++;
        $display("FAIL load_ready_early xfers=%0d ready=%b jam_rst=%b required 1 1", n, bus.in_ready, jam_rst);
      end
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) n++;
      c++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (n != 64) begin
      n_bad++;
      $display("FAIL load_count got=%0d required=64", n);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0 || jam_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL load_run_entry ready=%b jam_rst=%b required 0 0", bus.in_ready, jam_rst);
    end
    w = 3'd3; j = 3'd5; #1;
    n_cmp++;
    if (cost !== 7'd29) begin
      n_bad++;
      $display("FAIL cost_3_5 got=%0d required=29", cost);
    end
    w = 3'd7; j = 3'd7; #1;
    n_cmp++;
    if (cost !== 7'd63) begin
      n_bad++;
      $display("FAIL cost_7_7 got=%0d required=63", cost);
    end
    // In RUN an offered entry must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 7'h55;
    tick();
    bus.in_valid = 1'b0;
    w = 3'd0; j = 3'd0; #1;
    n_cmp++;
    if (cost !== 7'd0 || bus.in_ready !== 1'b0 || jam_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL run_ignores_stream cost=%0d ready=%b jam_rst=%b required 0 0 0", cost, bus.in_ready, jam_rst);
    end
    $display("test_load_gaps done transfers=%0d cycles=%0d", n, c);
  endtask

  task automatic test_capture();
    jam_valid = 1'b1;
    jam_min   = 10'd123;
    jam_count = 4'd4;
    tick();
    jam_valid = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_min !== 10'd123 || res_count !== 4'd4 ||
        bus.in_ready !== 1'b1 || jam_rst !== 1'b1 || res_err !== 1'b0) begin
      n_bad++;
      $display("FAIL capture rv=%b min=%0d cnt=%0d ready=%b jam_rst=%b err=%b required 1 123 4 1 1 0",
               res_valid, res_min, res_count, bus.in_ready, jam_rst, res_err);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0 || res_min !== 10'd123 || res_count !== 4'd4) begin
      n_bad++;
      $display("FAIL capture_hold rv=%b min=%0d cnt=%0d required 0 123 4", res_valid, res_min, res_count);
    end
    $display("test_capture done min=%0d cnt=%0d", res_min, res_count);
  endtask

  task automatic test_jam_in_load();
    jam_valid = 1'b1;
    jam_min   = 10'd55;
    jam_count = 4'd9;
    tick();
    jam_valid = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || res_min !== 10'd123 || res_count !== 4'd4 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL jam_in_load rv=%b min=%0d cnt=%0d ready=%b required 0 123 4 1",
               res_valid, res_min, res_count, bus.in_ready);
    end
    $display("test_jam_in_load done");
  endtask

  task automatic test_reset_midload();
    push_run(30, 64);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    w = 3'd0; j = 3'd5; #1;
    n_cmp++;
    if (cost !== 7'd0 || bus.in_ready !== 1'b1 || jam_rst !== 1'b1 || res_min !== 10'd0) begin
      n_bad++;
      $display("FAIL midload_reset cost=%0d ready=%b jam_rst=%b min=%0d required 0 1 1 0",
               cost, bus.in_ready, jam_rst, res_min);
    end
    push_run(63, 10);
    n_cmp++;
    if (jam_rst !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_63 jam_rst=%b ready=%b required 1 1", jam_rst, bus.in_ready);
    end
    push_run(1, 73);
    n_cmp++;
    if (jam_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_64 jam_rst=%b ready=%b required 0 0", jam_rst, bus.in_ready);
    end
    w = 3'd0; j = 3'd0; #1;
    n_cmp++;
    if (cost !== 7'd10) begin
      n_bad++;
      $display("FAIL reload_first got=%0d required=10", cost);
    end
    w = 3'd7; j = 3'd7; #1;
    n_cmp++;
    if (cost !== 7'd73) begin
      n_bad++;
      $display("FAIL reload_last got=%0d required=73", cost);
    end
    // Return to LOAD with a back-to-back capture so later tests start clean.
    jam_valid = 1'b1;
    jam_min   = 10'd1000;
    jam_count = 4'd15;
    tick();
    jam_valid = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_min !== 10'd1000 || res_count !== 4'd15 || jam_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back_capture rv=%b min=%0d cnt=%0d jam_rst=%b required 1 1000 15 1",
               res_valid, res_min, res_count, jam_rst);
    end
    $display("test_reset_midload done");
  endtask

`ifdef COST_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    push_run(64, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (res_valid !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0 || jam_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early pulses=%0d jam_rst=%b required 0 0", early, jam_rst);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_min !== 10'h3FF || res_count !== 4'd0 ||
        jam_rst !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_fire rv=%b err=%b min=%h cnt=%0d jam_rst=%b ready=%b required 1 1 3ff 0 1 1",
               res_valid, res_err, res_min, res_count, jam_rst, bus.in_ready);
    end
    push_run(64, 0);
    for (int k = 1; k <= 15; k++) tick();
    jam_valid = 1'b1;
    jam_min   = 10'd77;
    jam_count = 4'd3;
    tick();
    jam_valid = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_err !== 1'b0 || res_min !== 10'd77 || res_count !== 4'd3) begin
      n_bad++;
      $display("FAIL timeout_tie rv=%b err=%b min=%0d cnt=%0d required 1 0 77 3",
               res_valid, res_err, res_min, res_count);
    end
    $display("test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_load_gaps();
    test_capture();
    test_jam_in_load();
    test_reset_midload();
`ifdef COST_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cost_loader.md
# cost_loader

Front-end stage for the job-assignment core. It accepts an 8x8 worker/job cost matrix as a valid/ready stream of 7-bit entries and stores it in a register file. It serves the core's combinational W/J cost reads and holds the core in reset until a full matrix is present. When the core pulses Valid, the block captures MinCost/MatchCount into result registers and rearms for the next matrix.

## Interface
- TIMEOUT_CYCLES, 1048576: RUN cycles allowed before abort; only used with the timeout macro.
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- in_valid  in  1  stream entry valid.
- in_data  in  7  cost entry, row-major order (index = w*8+j).
- in_ready  out  1  block can accept an entry.
- JAM_RST  out  1  active-high reset to the assignment core.
- W  in  3  worker index from core.
- J  in  3  job index from core.
- Cost  out  7  stored entry at {W,J}, combinational.
- jam_valid  in  1  core result strobe.
- jam_min  in  10  core MinCost.
- jam_count  in  4  core MatchCount.
- res_valid  out  1  one-cycle result pulse.
- res_min  out  10  captured minimum cost.
- res_count  out  4  captured match count.
- res_err  out  1  one-cycle timeout pulse, coincident with res_valid.

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD:
  - in_ready=1. Transfer when in_valid & in_ready.
  - Each transfer writes mem[idx] <= in_data and increments the 6-bit idx.
  - The transfer at idx==63 moves to RUN and wraps idx to 0.
  - in_valid with in_ready=0 is ignored; upstream must hold data until ready.
- RUN:
  - in_ready=0. Wait for jam_valid.
  - On jam_valid: res_min <= jam_min, res_count <= jam_count, res_valid=1 for one cycle, then go to LOAD.
- jam_valid in LOAD is ignored.
- JAM_RST is a register. It is 1 in LOAD and 0 in RUN, so it changes on the same edge as the state.
- Cost = mem[{W,J}] in every state. A write is visible on Cost the cycle after its transfer.
- res_min/res_count hold their value until the next capture.
- Reset values:
  - in_ready=1, JAM_RST=1, res_valid=0, res_err=0, res_min=0, res_count=0.
  - All 64 mem entries=0, so Cost=0. idx=0.
- Reset mid-LOAD or mid-RUN: matrix discarded, idx=0, state LOAD, core held in reset again.

## Timing
- Throughput: one entry per cycle. 64 back-to-back transfers take 64 cycles.
- Edge k (the 64th transfer): in_ready falls and JAM_RST falls, both after edge k. The core leaves reset on edge k+1.
- jam_valid sampled high at edge t: res_valid=1 during cycle t..t+1. At edge t, JAM_RST=1 and in_ready=1.
- A new stream may start the cycle after capture.
- Full-matrix runs must not overlap. The core's Valid arrives in RUN only.

## Configuration
- COST_LOADER_TIMEOUT_EN defined:
  - A 21-bit counter clears on entry to RUN and increments each RUN cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without jam_valid, the block pulses res_valid and res_err, sets res_min=10'h3FF and res_count=0, and returns to LOAD.
  - If jam_valid arrives on the same cycle as the timeout, jam_valid wins: normal capture, res_err=0.
- Not defined: no counter, res_err tied 0, RUN waits indefinitely.

## Structure
- Package cost_loader_pkg holds:
  - Constants: N=8, COST_W=7, SUM_W=10, CNT_W=4, IDX_W=6.
  - State typedef: LOAD, RUN.
- Sub-module cost_mem: 64x7 register file with one synchronous write port (we, waddr[5:0], wdata), one combinational read port (raddr[5:0] = {W,J}), and clear on reset.
- Top level holds the FSM, idx counter, JAM_RST register, result registers and optional timeout counter.

## Test plan
- Reset: hold RST_N=0 for 2 cycles. Expect in_ready=1, JAM_RST=1, res_valid=0, res_min=0, res_count=0, Cost=0 for all W/J.
- Load with in_valid gaps (entry = (w*8+j)%100, every third cycle idle). Expect exactly 64 transfers; in_ready and JAM_RST fall after the 64th; W=3,J=5 gives Cost=29.
- In RUN, drive jam_valid=1, jam_min=10'd123, jam_count=4 for one cycle. Expect next cycle res_valid=1, res_min=123, res_count=4, in_ready=1, JAM_RST=1.
- jam_valid=1 with jam_min=55 while in LOAD. Expect no res_valid and res_min unchanged.
- RST_N=0 after 30 entries. Expect idx restart; a fresh 64-entry load is required before JAM_RST falls; Cost=0 before reload.
- With COST_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, load a matrix and never assert jam_valid. Expect res_valid=res_err=1 on RUN cycle 16, res_min=10'h3FF, res_count=0, return to LOAD. Repeat with jam_valid on cycle 16: normal capture, res_err=0.
